// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: command/state encodings and refresh interval shared by the arbiter and SDRAM_Ctrl
package sdram_arbiter_pkg;
  localparam int TREF_CYC = 1040;
  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_AREF = 2'b01,
    CMD_WR   = 2'b10,
    CMD_RD   = 2'b11
  } cmd_t;
  typedef enum logic [4:0] {
    ST_WAIT_INIT = 5'b00001,
    ST_ARB       = 5'b00010,
    ST_REF       = 5'b00100,
    ST_WR        = 5'b01000,
    ST_RD        = 5'b10000
  } state_t;
endpackage

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: refresh interval counter raising a pending request every TREF_CYC enabled cycles
module sdram_ref_timer #(
  parameter int TREF_CYC = sdram_arbiter_pkg::TREF_CYC,
  parameter int CNT_W    = 11
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic pending_o,
  output logic overrun_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, ovr_q, ovr_d, tc;
  // a fresh deadline beats a same-cycle clear so that request is never lost
  always_comb begin
    tc = en_i && (cnt_q == CNT_W'(TREF_CYC - 1));
    cnt_d = (en_i && !tc) ? cnt_q + 1'b1 : '0;
    pend_d = tc | (pend_q & ~clr_i);
    ovr_d = ovr_q | (tc & pend_q);
  end
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      pend_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
    end
  assign pending_o = pend_q;
  assign overrun_o = ovr_q;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: serialises auto-refresh, write and read bursts onto the SDRAM_Ctrl start/done handshake
// SDRAM_ARB_RR_EN: alternate write/read when both request; undefined gives write fixed priority over read
module sdram_arbiter #(
  parameter int TREF_CYC = sdram_arbiter_pkg::TREF_CYC,
  parameter int ADDR_W   = 24,
  parameter int CNT_W    = 11
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              cmd_start,
  output logic [1:0]        cmd_type,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_done,
  output logic              busy,
  output logic              ref_overrun
);
  import sdram_arbiter_pkg::*;
  state_t state_q, state_d;
  cmd_t type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic start_q, start_d, wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic ref_pending, ref_clr, grant_wr;
`ifdef SDRAM_ARB_RR_EN
  logic last_wr_q, last_wr_d;
  assign grant_wr = wr_req & ~(rd_req & last_wr_q);
`else
  assign grant_wr = wr_req;
`endif
  assign ref_clr = (state_q == ST_REF) & cmd_done;
  sdram_ref_timer #(.TREF_CYC(TREF_CYC), .CNT_W(CNT_W)) u_ref_timer (
    .sclk(sclk),
    .rst_n(rst_n),
    .en_i(init_done),
    .clr_i(ref_clr),
    .pending_o(ref_pending),
    .overrun_o(ref_overrun)
  );
  always_comb begin
    state_d = state_q;
    type_d = type_q;
    addr_d = addr_q;
    start_d = 1'b0;
    wr_ack_d = 1'b0;
    rd_ack_d = 1'b0;
`ifdef SDRAM_ARB_RR_EN
    last_wr_d = last_wr_q;
`endif
    case (state_q)
      ST_WAIT_INIT: state_d = init_done ? ST_ARB : ST_WAIT_INIT;
      ST_ARB:
        if (!init_done) state_d = ST_WAIT_INIT;
        else if (ref_pending) begin
          state_d = ST_REF;
          type_d = CMD_AREF;
          addr_d = '0;
          start_d = 1'b1;
        end else if (wr_req | rd_req) begin
          state_d = grant_wr ? ST_WR : ST_RD;
          type_d = grant_wr ? CMD_WR : CMD_RD;
          addr_d = grant_wr ? wr_addr : rd_addr;
          start_d = 1'b1;
        end
      ST_REF, ST_WR, ST_RD:
        if (cmd_done) begin
          state_d = init_done ? ST_ARB : ST_WAIT_INIT;
          type_d = CMD_NONE;
          addr_d = '0;
          wr_ack_d = state_q == ST_WR;
          rd_ack_d = state_q == ST_RD;
`ifdef SDRAM_ARB_RR_EN
          last_wr_d = (state_q == ST_REF) ? last_wr_q : (state_q == ST_WR);
`endif
        end
      default: state_d = ST_WAIT_INIT;
    endcase
  end
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_WAIT_INIT;
      type_q <= CMD_NONE;
      addr_q <= '0;
      start_q <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q <= type_d;
      addr_q <= addr_d;
      start_q <= start_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
    end
`ifdef SDRAM_ARB_RR_EN
  // reset value 0 means READ was served last, so the first contested grant goes to WRITE
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) last_wr_q <= 1'b0;
    else last_wr_q <= last_wr_d;
`endif
  assign cmd_start = start_q;
  assign cmd_type = type_q;
  assign cmd_addr = addr_q;
  assign wr_ack = wr_ack_q;
  assign rd_ack = rd_ack_q;
  assign busy = state_q inside {ST_REF, ST_WR, ST_RD};
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: randomized and directed stimulus checked cycle by cycle against a behavioural model
module tb_sdram_arbiter;
  localparam int TREF = 1040;
  logic sclk = 1'b0, rst_n = 1'b0, init_done = 1'b0;
  logic wr_req = 1'b0, rd_req = 1'b0, cmd_done = 1'b0;
  logic [23:0] wr_addr = '0, rd_addr = '0;
  logic wr_ack, rd_ack, cmd_start, busy, ref_overrun;
  logic [1:0] cmd_type;
  logic [23:0] cmd_addr;
  int n_chk = 0, n_pass = 0;
  always #5 sclk = ~sclk;
  sdram_arbiter #(.TREF_CYC(TREF), .ADDR_W(24), .CNT_W(11)) dut (
    .sclk(sclk), .rst_n(rst_n), .init_done(init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .cmd_start(cmd_start), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
    .cmd_done(cmd_done), .busy(busy), .ref_overrun(ref_overrun)
  );
  // behavioural model: m_st 0 waiting for init, 1 arbitrating, 2 operation in flight
  int m_st = 0, m_k = 0;
  logic [1:0] m_type = 2'd0;
  logic [23:0] m_addr = '0;
  bit m_start, m_wa, m_ra, m_pend, m_ovr;
`ifdef SDRAM_ARB_RR_EN
  bit m_last_wr;
`endif
  bit hold_req, auto_req, spur_en, rand_lat, rand_init, out;
  int lat = 1, cnt, cyc, done_cyc, start_cyc, wr_ack_cyc, n_wr_ack, n_rd_ack;
  logic [1:0] grants[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask
  task automatic model_step();
    bit tc, refdone, pend0, w;
    if (!rst_n) begin
      m_st = 0; m_type = 2'd0; m_addr = '0; m_start = 0; m_wa = 0; m_ra = 0;
      m_k = 0; m_pend = 0; m_ovr = 0;
`ifdef SDRAM_ARB_RR_EN
      m_last_wr = 0;
`endif
      return;
    end
    tc = 0;
    refdone = 0;
    if (init_done) begin
      m_k++;
      tc = (m_k % TREF) == 0;
    end else m_k = 0;
    pend0 = m_pend;
    m_start = 0; m_wa = 0; m_ra = 0;
    if (m_st == 0) begin
      if (init_done) m_st = 1;
    end else if (m_st == 1) begin
      if (!init_done) m_st = 0;
      else if (pend0) begin
        m_st = 2; m_type = 2'd1; m_addr = '0; m_start = 1;
      end else if (wr_req || rd_req) begin
`ifdef SDRAM_ARB_RR_EN
        w = wr_req && !(rd_req && m_last_wr);
`else
        w = wr_req;
`endif
        m_st = 2; m_type = w ? 2'd2 : 2'd3; m_addr = w ? wr_addr : rd_addr; m_start = 1;
      end
    end else if (cmd_done) begin
      m_wa = m_type == 2'd2;
      m_ra = m_type == 2'd3;
      refdone = m_type == 2'd1;
`ifdef SDRAM_ARB_RR_EN
      if (!refdone) m_last_wr = m_wa;
`endif
      m_type = 2'd0; m_addr = '0; m_st = init_done ? 1 : 0;
    end
    if (tc && pend0) m_ovr = 1;
    m_pend = tc || (pend0 && !refdone);
  endtask
  task automatic cycle();
    logic [30:0] got, exp;
    @(posedge sclk);
    #1;
    cyc++;
    model_step();
    got = {cmd_start, cmd_type, cmd_addr, wr_ack, rd_ack, busy, ref_overrun};
    exp = {m_start, m_type, m_addr, m_wa, m_ra, m_st == 2, m_ovr};
    chk("cycle", 64'(got), 64'(exp));
    if (cmd_start) begin grants.push_back(cmd_type); start_cyc = cyc; end
    if (wr_ack) begin n_wr_ack++; wr_ack_cyc = cyc; end
    if (rd_ack) n_rd_ack++;
    if (wr_ack && !hold_req) wr_req = 0;
    if (rd_ack && !hold_req) rd_req = 0;
    if (auto_req && !wr_req && $urandom_range(0, 3) == 0) begin wr_req = 1; wr_addr = 24'($urandom); end
    if (auto_req && !rd_req && $urandom_range(0, 3) == 0) begin rd_req = 1; rd_addr = 24'($urandom); end
    cmd_done = 0;
    if (!rst_n) out = 0;
    else if (cmd_start) begin out = 1; cnt = lat; end
    else if (out) begin
      cnt--;
      if (cnt <= 0) begin cmd_done = 1; out = 0; done_cyc = cyc; end
    end else if (spur_en && !busy && $urandom_range(0, 15) == 0) cmd_done = 1;
    if (rand_lat) lat = $urandom_range(1, 8);
    if (rand_init && $urandom_range(0, 499) == 0) init_done = ~init_done;
  endtask
  task automatic run(input int n);
    repeat (n) cycle();
  endtask
  task automatic wait_start(input string tag, input int budget, output int n);
    n = 0;
    do begin cycle(); n++; end while (!cmd_start && n < budget);
    if (!cmd_start) chk({tag, "_timeout"}, 64'(0), 64'(1));
  endtask
  initial begin
    int n, s0;
    logic [1:0] seq[$];
    logic [1:0] exp_g;
    rst_n = 0;
    run(3);
    chk("rst_outs", 64'({cmd_start, cmd_type, cmd_addr, wr_ack, rd_ack, busy, ref_overrun}), 64'(0));
    rst_n = 1;
    run(2000);
    chk("pre_init_starts", 64'(grants.size()), 64'(0));
    init_done = 1;
    wait_start("first_aref", 1200, n);
    chk("first_aref_lat", 64'(n), 64'(1041));
    chk("first_aref_type", 64'(cmd_type), 64'(1));
    run(5);
    wr_addr = 24'h123456; wr_req = 1; lat = 10; n_wr_ack = 0;
    wait_start("wr", 20, n);
    chk("wr_type", 64'(cmd_type), 64'(2));
    chk("wr_addr", 64'(cmd_addr), 64'(24'h123456));
    run(15);
    chk("wr_ack_count", 64'(n_wr_ack), 64'(1));
    chk("wr_ack_timing", 64'(wr_ack_cyc), 64'(done_cyc + 1));
    chk("wr_done_lat", 64'(done_cyc - start_cyc), 64'(10));
    rst_n = 0;
    run(2);
    rst_n = 1;
    lat = 1; hold_req = 1;
    wr_req = 1; wr_addr = 24'hABCDEF; rd_req = 1; rd_addr = 24'h00FACE;
    n = 0;
    while (seq.size() < 4 && n < 100) begin
      cycle();
      n++;
      if (cmd_start && cmd_type != 2'd1) seq.push_back(cmd_type);
    end
    chk("both_grants", 64'(seq.size()), 64'(4));
    for (int i = 0; i < seq.size(); i++) begin
`ifdef SDRAM_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 2'd2 : 2'd3;
`else
      exp_g = 2'd2;
`endif
      chk($sformatf("both_seq%0d", i), 64'(seq[i]), 64'(exp_g));
    end
    hold_req = 0; wr_req = 0; rd_req = 0;
    run(10);
    n = 0;
    while (!((m_k % TREF) == TREF - 8 && !busy) && n < 3000) begin cycle(); n++; end
    chk("ref_align", 64'(n < 3000), 64'(1));
    grants.delete();
    wr_req = 1; wr_addr = 24'h0F0F0F; lat = 20;
    run(3);
    rd_req = 1; rd_addr = 24'h707070;
    n = 0;
    while (grants.size() < 3 && n < 200) begin cycle(); n++; end
    chk("ref_mid_wr_n", 64'(grants.size()), 64'(3));
    if (grants.size() >= 3) begin
      chk("ref_mid_wr_g0", 64'(grants[0]), 64'(2));
      chk("ref_mid_wr_g1", 64'(grants[1]), 64'(1));
      chk("ref_mid_wr_g2", 64'(grants[2]), 64'(3));
    end
    lat = 1;
    run(30);
    lat = 2200;
    n = 0;
    while (!ref_overrun && n < 3500) begin cycle(); n++; end
    chk("ovr_set", 64'(ref_overrun), 64'(1));
    n = 0;
    while (busy && n < 3000) begin cycle(); n++; end
    lat = 1;
    run(1500);
    chk("ovr_sticky", 64'(ref_overrun), 64'(1));
    rd_req = 1; rd_addr = 24'h5A5A5A; lat = 50;
    n = 0;
    do begin cycle(); n++; end while (!(cmd_start && cmd_type == 2'd3) && n < 2000);
    chk("rd_start", 64'(cmd_type), 64'(3));
    run(5);
    rst_n = 0;
    #1;
    chk("rst_mid_type", 64'(cmd_type), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_ovr", 64'(ref_overrun), 64'(0));
    n_rd_ack = 0; init_done = 0;
    run(3);
    rst_n = 1;
    s0 = grants.size();
    run(20);
    chk("rst_no_ack", 64'(n_rd_ack), 64'(0));
    chk("wait_init_starts", 64'(grants.size() - s0), 64'(0));
    init_done = 1;
    wait_start("post_rst", 10, n);
    chk("post_rst_lat", 64'(n), 64'(2));
    chk("post_rst_rd", 64'(cmd_type), 64'(3));
    auto_req = 1; spur_en = 1; rand_lat = 1; rand_init = 1;
    run(6000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Sits directly upstream of the SDRAM command controller (SDRAM_Ctrl). Selects, one at a time, between periodic auto-refresh, camera write bursts and display read bursts.
- Hands each selected operation to the controller with a start/done handshake.
- Owns the refresh interval timer so the controller never has to track refresh deadlines itself.

Parameters:
- TREF_CYC, 1040, sclk cycles between refresh requests (7.8 us at 133 MHz).
- ADDR_W, 24, word address width: bank 2 + row 13 + col 9.
- CNT_W, 11, refresh counter width; must satisfy 2^CNT_W > TREF_CYC.

Ports:
- sclk  in  1  system clock, 133 MHz.
- rst_n  in  1  asynchronous active-low reset.
- init_done  in  1  controller power-up init sequence complete; level signal.
- wr_req  in  1  write burst requested; held until wr_ack.
- wr_addr  in  ADDR_W  burst start address; stable while wr_req is high.
- wr_ack  out  1  one-cycle pulse, write burst completed.
- rd_req  in  1  read burst requested; held until rd_ack.
- rd_addr  in  ADDR_W  burst start address; stable while rd_req is high.
- rd_ack  out  1  one-cycle pulse, read burst completed.
- cmd_start  out  1  one-cycle pulse to the controller.
- cmd_type  out  2  00 none, 01 AREF, 10 WRITE, 11 READ; held from cmd_start until cmd_done.
- cmd_addr  out  ADDR_W  latched address for WRITE/READ; 0 for AREF.
- cmd_done  in  1  one-cycle pulse from the controller, operation finished.
- busy  out  1  high in REF, WRITE and READ states.
- ref_overrun  out  1  sticky error: a refresh deadline was missed.

Behaviour:
- Reset: all outputs 0. State = WAIT_INIT. ref_cnt = 0, ref_pending = 0, last_served = READ.
- Refresh timer:
  - Counts only while init_done = 1; otherwise held at 0.
  - When ref_cnt == TREF_CYC-1: ref_cnt goes to 0 and ref_pending is set.
  - If ref_pending is already 1 at that terminal count, ref_overrun is set. It clears only on reset.
  - ref_pending clears in the cycle cmd_done is seen in REF.
  - If terminal count and that clear happen in the same cycle, ref_pending stays 1, because a new request wins.
- States:
  - WAIT_INIT → ARB when init_done = 1.
  - ARB (priority):
    - ref_pending → REF.
    - Otherwise, if only wr_req or only rd_req is high, go to that one.
    - If both are high, the request type not equal to last_served goes (alternation).
    - If none, stay in ARB.
  - Entry into REF, WRITE or READ (registered):
    - cmd_start = 1 for exactly the first cycle.
    - cmd_type and cmd_addr are set in that same cycle and held.
    - Address is latched from wr_addr or rd_addr on the ARB exit edge.
  - REF, WRITE, READ: wait for cmd_done. Then go to ARB, or to WAIT_INIT if init_done = 0.
    - On that same clock edge: wr_ack (WRITE) or rd_ack (READ) pulses for one cycle, last_served updates, cmd_type returns to 00.
    - REF does not update last_served.
- Latency: request visible in ARB at cycle N → cmd_start at N+1 → ack in the cycle after cmd_done. Minimum gap between consecutive cmd_start pulses is 2 cycles (one ARB cycle in between).
- init_done drop:
  - In ARB: go to WAIT_INIT next cycle.
  - Mid-operation: finish the current operation first; no abort.
- cmd_done outside REF/WRITE/READ is ignored.
- A requester deasserting its req before ack is a protocol violation. The burst still completes and is acked.
- rst_n asserted mid-operation: immediate return to reset values. No ack is issued.

Optional Feature:
- SDRAM_ARB_RR_EN.
- Defined: alternating write/read arbitration as described above.
- Undefined: fixed priority, WRITE over READ whenever both are requested. last_served is not implemented; refresh still has top priority.

Decomposition:
- Shared package holds:
  - cmd_type encodings CMD_NONE/CMD_AREF/CMD_WR/CMD_RD.
  - State encodings ST_WAIT_INIT/ST_ARB/ST_REF/ST_WR/ST_RD (one-hot).
  - Timing constant TREF_CYC, reused by the controller for consistency.
- One sub-module is natural: sdram_ref_timer (counter, ref_pending, ref_overrun, clear input).

Test Plan:
- init_done low for 2000 cycles → no cmd_start, ref_cnt stays 0. Then raise init_done with no requests → first cmd_start with cmd_type = 01 at exactly 1041 cycles after init_done rose (1040 count + 1 registration).
- wr_req = 1, wr_addr = 24'h12_3456 in ARB; cmd_done returned 10 cycles after cmd_start → cmd_type = 10, cmd_addr = 24'h123456, single wr_ack in the cycle after cmd_done.
- wr_req and rd_req both held high, immediate cmd_done each time:
  - With SDRAM_ARB_RR_EN: sequence W,R,W,R.
  - Without it: W,W,W,W.
- Refresh terminal count while a WRITE is in progress → write completes with ack, then REF is issued next, before any pending rd_req.
- cmd_done withheld for 2200 cycles in REF → ref_overrun = 1 and stays 1 after later completions; clears only on rst_n.
- rst_n pulsed low during READ → cmd_type = 00, no rd_ack. After release the block waits in WAIT_INIT until init_done = 1.
